// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel point-operation engine: operation codes,
// op-select width and the default {r,g,b} pixel layout.
package pixel_pkg;

   localparam int PIX_DW = 8;
   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_PASS   = 3'd0,
      MODE_ADD    = 3'd1,
      MODE_SUB    = 3'd2,
      MODE_INV    = 3'd3,
      MODE_THRESH = 3'd4
   } mode_e;

   // Packed so that r sits in the MSBs and b in the LSBs, matching the stream packing.
   typedef struct packed {
      logic [PIX_DW-1:0] r;
      logic [PIX_DW-1:0] g;
      logic [PIX_DW-1:0] b;
   } pixel_t;

endpackage

// File: rtl/pixel_point_engine_if.sv
// Input and output stream signals of the pixel point engine.
// slave: the engine side; master: the source/sink environment side.
interface pixel_point_engine_if #(
   parameter int PIX_PER_CLK = 2,
   parameter int DW          = 8
);
   localparam int BW = 3 * DW * PIX_PER_CLK;

   logic          s_valid;
   logic          s_ready;
   logic [BW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [BW-1:0] m_data;
   logic          m_sof;
   logic          m_eol;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_sof, m_eol
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_sof, m_eol
   );
endinterface

// File: rtl/pixel_point_op.sv
// Combinational point operation on one {R,G,B} pixel.
// Optional feature macro: PIXEL_THRESHOLD_EN (mode 4 becomes a luminance
// threshold; without it mode 4 passes the pixel and no threshold logic exists).
module pixel_point_op
   import pixel_pkg::*;
#(
   parameter int DW = PIX_DW
) (
   input  logic [MODE_W-1:0] mode,
   input  logic [DW-1:0]     value,
   input  logic [3*DW-1:0]   pix_in,
   output logic [3*DW-1:0]   pix_out
);

   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] x, input logic [DW-1:0] v);
      logic [DW:0] s;
      s = {1'b0, x} + {1'b0, v};
      return s[DW] ? {DW{1'b1}} : s[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] x, input logic [DW-1:0] v);
      return (x > v) ? (x - v) : '0;
   endfunction

   logic [DW-1:0] r, g, b;
   assign {r, g, b} = pix_in;

`ifdef PIXEL_THRESHOLD_EN
   // Compare R+G+B against 3*v instead of dividing the sum by three.
   logic [DW+1:0] sum;
   logic [DW+1:0] thr;
   logic          hit;
   assign sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
   assign thr = {2'b00, value} + {1'b0, value, 1'b0};
   assign hit = (sum >= thr);
`endif

   // Apply the frame's operation to each channel; unused codes pass through.
   always_comb begin
      pix_out = pix_in;
      case (mode)
         MODE_ADD: pix_out = {sat_add(r, value), sat_add(g, value), sat_add(b, value)};
         MODE_SUB: pix_out = {sat_sub(r, value), sat_sub(g, value), sat_sub(b, value)};
         MODE_INV: pix_out = ~pix_in;
`ifdef PIXEL_THRESHOLD_EN
         MODE_THRESH: pix_out = hit ? {3*DW{1'b1}} : '0;
`endif
         default:  pix_out = pix_in;
      endcase
   end

endmodule

// File: rtl/pixel_point_engine.sv
// Streaming point-operation engine: PIX_PER_CLK RGB pixels per beat, one
// operation per frame, 2-stage pipeline stalled as a whole on backpressure.
// Optional feature macro: PIXEL_THRESHOLD_EN (threshold op for mode 4).
module pixel_point_engine
   import pixel_pkg::*;
#(
   parameter int WIDTH       = 768,
   parameter int HEIGHT      = 512,
   parameter int PIX_PER_CLK = 2,
   parameter int DW          = 8
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic [MODE_W-1:0] op_mode,
   input  logic [DW-1:0]     op_value,
   pixel_point_engine_if.slave bus,
   output logic              frame_done
);

   localparam int COLS  = WIDTH / PIX_PER_CLK;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int PW    = 3 * DW;
   localparam int BW    = PW * PIX_PER_CLK;

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [MODE_W-1:0] mode_q;
   logic [DW-1:0]     val_q;

   logic en, s_ready_i, xfer;
   logic sof_in, eol_in, eof_in;
   logic [MODE_W-1:0] mode_in;
   logic [DW-1:0]     val_in;

   logic              vld_p1, sof_p1, eol_p1, eof_p1;
   logic [MODE_W-1:0] mode_p1;
   logic [DW-1:0]     val_p1;
   logic [BW-1:0]     data_p1;
   logic [BW-1:0]     op_res;

   logic              vld_p2, sof_p2, eol_p2, eof_p2;
   logic [BW-1:0]     data_p2;

   assign en        = !vld_p2 || bus.m_ready;
   assign s_ready_i = en && !HRESET;
   assign xfer      = bus.s_valid && s_ready_i;

   assign sof_in = (col == '0) && (row == '0);
   assign eol_in = (col == COL_W'(COLS - 1));
   assign eof_in = eol_in && (row == ROW_W'(HEIGHT - 1));

   // The frame-start beat must already use the mode presented with it.
   assign mode_in = sof_in ? op_mode  : mode_q;
   assign val_in  = sof_in ? op_value : val_q;

   // Position counters and per-frame operation registers, advanced on input transfers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         col    <= '0;
         row    <= '0;
         mode_q <= MODE_PASS;
         val_q  <= '0;
      end else if (xfer) begin
         if (sof_in) begin
            mode_q <= op_mode;
            val_q  <= op_value;
         end
         if (eol_in) begin
            col <= '0;
            row <= eof_in ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // ---- stage 1: register accepted beat, its flags and its operation ----
   // Control side of stage 1; a bubble loads vld_p1=0.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         vld_p1  <= 1'b0;
         sof_p1  <= 1'b0;
         eol_p1  <= 1'b0;
         eof_p1  <= 1'b0;
         mode_p1 <= MODE_PASS;
         val_p1  <= '0;
      end else if (en) begin
         vld_p1  <= xfer;
         sof_p1  <= sof_in;
         eol_p1  <= eol_in;
         eof_p1  <= eof_in;
         mode_p1 <= mode_in;
         val_p1  <= val_in;
      end
   end

   // Stage-1 pixel data; qualified by vld_p1 so it needs no reset.
   always_ff @(posedge HCLK) begin
      if (en) data_p1 <= bus.s_data;
   end

   for (genvar p = 0; p < PIX_PER_CLK; p++) begin : g_op
      pixel_point_op #(.DW(DW)) u_op (
         .mode    (mode_p1),
         .value   (val_p1),
         .pix_in  (data_p1[p*PW +: PW]),
         .pix_out (op_res[p*PW +: PW])
      );
   end

   // ---- stage 2: register op result; holds while the sink stalls ----
   // Output register; markers are gated by the beat's valid so bubbles never carry flags.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         vld_p2  <= 1'b0;
         sof_p2  <= 1'b0;
         eol_p2  <= 1'b0;
         eof_p2  <= 1'b0;
         data_p2 <= '0;
      end else if (en) begin
         vld_p2  <= vld_p1;
         sof_p2  <= vld_p1 && sof_p1;
         eol_p2  <= vld_p1 && eol_p1;
         eof_p2  <= vld_p1 && eof_p1;
         data_p2 <= op_res;
      end
   end

   // Pulse one cycle after the last beat of the frame leaves the engine.
   always_ff @(posedge HCLK) begin
      if (HRESET) frame_done <= 1'b0;
      else        frame_done <= vld_p2 && bus.m_ready && eof_p2;
   end

   assign bus.s_ready = s_ready_i;
   assign bus.m_valid = vld_p2;
   assign bus.m_data  = data_p2;
   assign bus.m_sof   = sof_p2;
   assign bus.m_eol   = eol_p2;

endmodule

// File: tb/tb_pixel_point_engine.sv
// Directed bench for pixel_point_engine with a scoreboard of expected beats.
// Honours PIXEL_THRESHOLD_EN when building expectations for mode 4.
module tb_pixel_point_engine;
   import pixel_pkg::*;

   localparam int WIDTH  = 8;
   localparam int HEIGHT = 2;
   localparam int PPC    = 2;
   localparam int DW     = 8;
   localparam int BW     = 3 * DW * PPC;
   localparam int COLS   = WIDTH / PPC;

   typedef struct {
      logic [BW-1:0] d;
      logic          sof;
      logic          eol;
      logic          eof;
      int            cyc;
      bit            lat;
   } exp_t;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b1;
   logic [2:0]    op_mode = 3'd0;
   logic [7:0]    op_value = 8'd0;
   logic          frame_done;

   exp_t          sb[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            m_col    = 0;
   int            m_row    = 0;
   logic [2:0]    f_mode   = 3'd0;
   logic [7:0]    f_val    = 8'd0;
   bit            lat_on   = 1'b1;
   bit            fd_exp   = 1'b0;
   bit            held_vld = 1'b0;
   logic [BW-1:0] held_d;
   logic          held_sof, held_eol;

   pixel_point_engine_if #(.PIX_PER_CLK(PPC), .DW(DW)) bus_if ();

   pixel_point_engine #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_PER_CLK(PPC), .DW(DW)
   ) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .op_mode    (op_mode),
      .op_value   (op_value),
      .bus        (bus_if),
      .frame_done (frame_done)
   );

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] ch_add(input int x, input int v);
      int t;
      t = x + v;
      return (t > 255) ? 8'd255 : 8'(t);
   endfunction

   function automatic logic [7:0] ch_sub(input int x, input int v);
      return (x - v < 0) ? 8'd0 : 8'(x - v);
   endfunction

   // Reference result for one beat, built channel by channel with integer arithmetic.
   function automatic logic [BW-1:0] model(input logic [2:0] md, input logic [7:0] v, input logic [BW-1:0] d);
      logic [BW-1:0] res;
      pixel_t pi, po;
      int s;
      res = '0;
      for (int p = 0; p < PPC; p++) begin
         pi = d[p*24 +: 24];
         po = pi;
         case (md)
            3'd1: begin po.r = ch_add(pi.r, v); po.g = ch_add(pi.g, v); po.b = ch_add(pi.b, v); end
            3'd2: begin po.r = ch_sub(pi.r, v); po.g = ch_sub(pi.g, v); po.b = ch_sub(pi.b, v); end
            3'd3: begin po.r = 8'(255 - pi.r); po.g = 8'(255 - pi.g); po.b = 8'(255 - pi.b); end
`ifdef PIXEL_THRESHOLD_EN
            3'd4: begin
               s = int'(pi.r) + int'(pi.g) + int'(pi.b);
               po = (s >= 3 * int'(v)) ? 24'hFFFFFF : 24'h000000;
            end
`endif
            default: po = pi;
         endcase
         res[p*24 +: 24] = po;
      end
      return res;
   endfunction

   function automatic logic [BW-1:0] px2(input logic [7:0] r0, g0, b0, r1, g1, b1);
      pixel_t a, b;
      a.r = r0; a.g = g0; a.b = b0;
      b.r = r1; b.g = g1; b.b = b1;
      return {b, a};
   endfunction

   function automatic logic [BW-1:0] rnd();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[BW-1:0];
   endfunction

   // Present one beat, wait (bounded) for acceptance, then record its expected output.
   task automatic send_beat(input logic [BW-1:0] d);
      bit ok;
      int waited;
      exp_t e;
      ok = 1'b0;
      waited = 0;
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = d;
      while (!ok && waited < 50) begin
         @(negedge HCLK);
         ok = (bus_if.s_ready === 1'b1);
         @(posedge HCLK);
         #1;
         waited++;
      end
      chk("s_ready_wait", 64'(ok), 64'd1);
      bus_if.s_valid = 1'b0;
      if (ok) begin
         if (m_col == 0 && m_row == 0) begin
            f_mode = op_mode;
            f_val  = op_value;
         end
         e.d   = model(f_mode, f_val, d);
         e.sof = (m_col == 0 && m_row == 0);
         e.eol = (m_col == COLS - 1);
         e.eof = e.eol && (m_row == HEIGHT - 1);
         e.cyc = cyc;
         e.lat = lat_on;
         sb.push_back(e);
         if (m_col == COLS - 1) begin
            m_col = 0;
            m_row = (m_row == HEIGHT - 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
   endtask

   task automatic frame(input logic [2:0] md, input logic [7:0] v, input logic [BW-1:0] b0,
                        input logic [BW-1:0] b1, input int gap, input bit chg);
      op_mode  = md;
      op_value = v;
      for (int i = 0; i < HEIGHT * COLS; i++) begin
         if (chg && i == 3) begin
            op_mode  = MODE_ADD;
            op_value = 8'd9;
         end
         send_beat((i == 0) ? b0 : (i == 1) ? b1 : rnd());
         if (gap > 0) repeat (gap) @(posedge HCLK);
         if (gap > 0) #1;
      end
   endtask

   // Output monitor: pops the scoreboard, checks hold-under-stall and frame_done.
   always @(negedge HCLK) begin
      exp_t e;
      if (HRESET) begin
         sb.delete();
         fd_exp   = 1'b0;
         held_vld = 1'b0;
      end else begin
         chk("frame_done", 64'(frame_done), 64'(fd_exp));
         if (held_vld) begin
            chk("hold_valid", 64'(bus_if.m_valid), 64'd1);
            chk("hold_data", 64'(bus_if.m_data), 64'(held_d));
            chk("hold_sof", 64'(bus_if.m_sof), 64'(held_sof));
            chk("hold_eol", 64'(bus_if.m_eol), 64'(held_eol));
         end
         fd_exp = 1'b0;
         if (bus_if.m_valid === 1'b1 && bus_if.m_ready === 1'b1) begin
            if (sb.size() == 0) begin
               chk("beat_expected", 64'(sb.size() != 0), 64'd1);
            end else begin
               e = sb.pop_front();
               chk("m_data", 64'(bus_if.m_data), 64'(e.d));
               chk("m_sof", 64'(bus_if.m_sof), 64'(e.sof));
               chk("m_eol", 64'(bus_if.m_eol), 64'(e.eol));
               if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd1);
               fd_exp = e.eof;
            end
         end
         held_vld = (bus_if.m_valid === 1'b1) && (bus_if.m_ready === 1'b0);
         held_d   = bus_if.m_data;
         held_sof = bus_if.m_sof;
         held_eol = bus_if.m_eol;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      HRESET         = 1'b1;
      bus_if.s_valid = 1'b0;
      bus_if.s_data  = '0;
      bus_if.m_ready = 1'b1;
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_m_valid", 64'(bus_if.m_valid), 64'd0);
      chk("rst_m_data", 64'(bus_if.m_data), 64'd0);
      chk("rst_m_sof", 64'(bus_if.m_sof), 64'd0);
      chk("rst_m_eol", 64'(bus_if.m_eol), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_s_ready", 64'(bus_if.s_ready), 64'd0);
      HRESET = 1'b0;
      #1;
      chk("post_rst_s_ready", 64'(bus_if.s_ready), 64'd1);

      // PASS, back-to-back, then ADD with bubbles, then SUB.
      frame(MODE_PASS, 8'd0, px2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6), rnd(), 0, 1'b0);
      frame(MODE_ADD, 8'd100, px2(8'd200, 8'd10, 8'd155, 8'd0, 8'd255, 8'd1), rnd(), 1, 1'b0);
      frame(MODE_SUB, 8'd50, px2(8'd30, 8'd50, 8'd51, 8'd255, 8'd0, 8'd49), rnd(), 0, 1'b0);

      // INV with op_mode switched to ADD mid-frame; the next frame picks ADD up.
      frame(MODE_INV, 8'd0, px2(8'h12, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01), rnd(), 0, 1'b1);

      // ADD under 5 cycles of backpressure.
      lat_on = 1'b0;
      fork
         frame(MODE_ADD, 8'd7, px2(8'd250, 8'd3, 8'd9, 8'd248, 8'd249, 8'd0), rnd(), 0, 1'b0);
         begin
            repeat (3) @(posedge HCLK);
            #1;
            bus_if.m_ready = 1'b0;
            #1;
            chk("stall_s_ready", 64'(bus_if.s_ready), 64'd0);
            repeat (5) @(posedge HCLK);
            #1;
            chk("stall_m_valid", 64'(bus_if.m_valid), 64'd1);
            bus_if.m_ready = 1'b1;
         end
      join
      lat_on = 1'b1;

      // Reset while beat 5 of a SUB frame is presented.
      op_mode  = MODE_SUB;
      op_value = 8'd1;
      for (int i = 0; i < 5; i++) send_beat(rnd());
      HRESET         = 1'b1;
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = rnd();
      @(posedge HCLK);
      #1;
      chk("abort_m_valid", 64'(bus_if.m_valid), 64'd0);
      chk("abort_s_ready", 64'(bus_if.s_ready), 64'd0);
      m_col          = 0;
      m_row          = 0;
      HRESET         = 1'b0;
      bus_if.s_valid = 1'b0;
      #1;
      chk("abort_s_ready_after", 64'(bus_if.s_ready), 64'd1);
      frame(MODE_INV, 8'd0, px2(8'h00, 8'h01, 8'hFE, 8'h55, 8'hAA, 8'h33), rnd(), 0, 1'b0);

      // Threshold boundary: sum equal to 3*v and one below it.
      frame(MODE_THRESH, 8'd100, px2(8'd100, 8'd100, 8'd100, 8'd99, 8'd100, 8'd100), rnd(), 0, 1'b0);

      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(posedge HCLK);
         w++;
      end
      repeat (4) @(posedge HCLK);
      #1;
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_point_engine.md
# pixel_point_engine

Parametrised streaming point-operation engine for the image pipeline. It sits between the pixel source (hex-file reader) and the BMP writer. It accepts PIX_PER_CLK RGB pixels per beat over a valid/ready handshake and applies one per-frame-selected operation: pass, saturating brighten, saturating darken, invert, or optional threshold. It emits the result stream with start-of-frame and end-of-line markers and a frame-done pulse.

## Interface
- WIDTH, 768: image width in pixels; must be a multiple of PIX_PER_CLK.
- HEIGHT, 512: image height in lines.
- PIX_PER_CLK, 2: pixels per beat (1, 2, 4 supported); pixel 0 is the even pixel.
- DW, 8: bits per colour channel.

Ports:
- HCLK  in  1  sole clock; all logic on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- op_mode  in  3  operation select; sampled only at frame start.
- op_value  in  DW  operand for brighten, darken and threshold; sampled with op_mode.
- s_valid  in  1  input beat valid.
- s_ready  out  1  engine can accept a beat.
- s_data  in  3*DW*PIX_PER_CLK  pixels packed {R,G,B} per pixel, pixel 0 in the LSBs.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  3*DW*PIX_PER_CLK  processed pixels, same packing.
- m_sof  out  1  first beat of frame (qualified by m_valid).
- m_eol  out  1  last beat of a line (qualified by m_valid).
- frame_done  out  1  one-cycle pulse after the last beat of the frame is accepted.

## Operation
- Input counters: col counts 0..WIDTH/PIX_PER_CLK-1 and row counts 0..HEIGHT-1. Both advance on each input transfer (s_valid & s_ready). col wraps to 0 and increments row. row wraps to 0 after the last line.
- Frame start is an input transfer with col=0 and row=0. On that transfer op_mode and op_value latch into the frame registers and hold for the whole frame. Mid-frame changes on op_mode and op_value are ignored.
- Modes, applied per channel:
  - 0 PASS: y = x.
  - 1 ADD: y = min(x+v, 2^DW-1), computed at DW+1 bits.
  - 2 SUB: y = max(x-v, 0).
  - 3 INV: y = ~x.
  - 4 THRESH: see Configuration.
  - 5–7: PASS.
- The first beat of a frame uses the newly latched mode.
- sof/eol/eof flags are generated from the input counters and travel with the data through the pipeline.
- frame_done asserts the cycle after the output transfer carrying eof, i.e. row=HEIGHT-1 and last col.

## Timing
- 2-stage pipeline: stage 1 registers the input and flags; stage 2 registers the op result. Latency is 2 cycles from input transfer to m_valid with no stall.
- Advance enable: en = !m_valid | m_ready. s_ready = en. Both stages load only when en=1, so the whole pipeline stalls on backpressure.
- While m_valid=1 and m_ready=0, m_data, m_sof and m_eol hold stable. No beat is dropped or duplicated.
- A bubble (s_valid=0 with en=1) propagates as stage-valid=0.
- Full throughput is 1 beat/cycle with m_ready tied high.
- Reset values: s_ready=0 during reset and 1 the cycle after. m_valid=0, m_data=0, m_sof=0, m_eol=0, frame_done=0. col=row=0. Frame registers are PASS/0.
- Reset mid-frame discards all in-flight beats. The next accepted beat is treated as frame start. No frame_done is generated for the aborted frame.
- A frame-start transfer and frame_done of the previous frame in the same cycle are legal and independent.

## Configuration
- PIXEL_THRESHOLD_EN defined: mode 4 is THRESH. For each pixel compute s = R+G+B at DW+2 bits and t = 3*v at DW+2 bits. All three channels become 2^DW-1 if s >= t, else 0.
- Not defined: mode 4 behaves as PASS and no threshold adder or comparator logic is built.

## Structure
- Shared package pixel_pkg holds:
  - mode constants MODE_PASS, MODE_ADD, MODE_SUB, MODE_INV, MODE_THRESH;
  - the op_mode width constant;
  - a pixel struct typedef {r,g,b}, DW-parametrised through a package localparam of 8.
- Sub-module pixel_point_op: combinational op for a single pixel (mode, value, pixel in → pixel out). It is instantiated PIX_PER_CLK times by a generate loop feeding stage 2.
- Counters, frame registers, flag pipeline and handshake live in the top module.

## Test plan
- PASS, WIDTH=8, HEIGHT=2, PIX_PER_CLK=2, m_ready=1, 8 beats -> output identical to input after 2 cycles. m_sof on beat 0, m_eol on beats 3 and 7, frame_done 1 cycle after beat 7.
- ADD v=100, inputs R=200,G=10,B=155 -> outputs 255,110,255. SUB v=50, inputs 30,50,51 -> outputs 0,0,1.
- INV, 0x12/0x00/0xFF -> 0xED/0xFF/0x00. op_mode changed to ADD mid-frame -> remains INV until the next frame start.
- Backpressure: m_ready low for 5 cycles mid-stream -> s_ready low, m_data stable, no loss. The output sequence matches the input order exactly.
- HRESET pulsed at beat 5 of a frame -> m_valid=0 next cycle, no frame_done. The next beat gets m_sof and latches the new mode.
- THRESH v=100 with PIXEL_THRESHOLD_EN: pixel 100,100,100 -> 255,255,255 and 99,100,100 -> 0,0,0. Without the macro both pixels pass through unchanged.
